// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - shared mini-cpu datapath types
package mini_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, with borrow/zero/overflow flags
module serial_subtractor
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             a_msb;
  logic             b_msb;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sum;
  logic             carry_out;

  // a + ~b + 1: the inversion sits on the adder input, carry seeded with 1 at accept
  full_adder u_fa (
    .sum       (sum),
    .carry_out (carry_out),
    .a         (a_sh[0]),
    .b         (~b_sh[0]),
    .carry_in  (carry)
  );

  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = sum;
  end

  assign result = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            carry    <= 1'b1;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res   <= res_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_out;
          count <= count + CW'(1);
          if (count == LAST) begin
            borrow    <= ~carry_out;
            zero      <= (res_next == '0);
            overflow  <= (a_msb != b_msb) && (sum != a_msb);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed bench for serial_subtractor (WIDTH=8 and WIDTH=1)
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic       borrow, zero, overflow;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0] a1, b1, result1;
  logic       borrow1, zero1, overflow1;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .borrow(borrow), .zero(zero), .overflow(overflow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .borrow(borrow1), .zero(zero1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // accept a pair, count edges to out_valid, check result and flags, then the return to idle
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] er,
                        input logic eb, input logic ez, input logic eo);
    int n;
    @(negedge clk);
    chk("in_ready_pre", in_ready, 1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    chk("latency", n, 8);
    @(negedge clk);
    chk("result", result, er);
    chk("borrow", borrow, eb);
    chk("zero", zero, ez);
    chk("overflow", overflow, eo);
    @(posedge clk);
    #1;
    chk("in_ready_post", in_ready, 1);
    chk("out_valid_post", out_valid, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {borrow, zero, overflow}, 0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
    run_op(8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0);

    // backpressure: 0x10 - 0x20 = 0xF0 held in DONE while a new pair is offered
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !out_valid) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("bp_latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h33; b = 8'h11;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 8'hF0);
      chk("bp_flags", {borrow, zero, overflow}, 3'b100);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("idle_hold_result", result, 8'hF0);

    // reset three cycles into SHIFT, after some result bits have shifted in
    @(negedge clk);
    in_valid = 1'b1; a = 8'h00; b = 8'h11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);

    // WIDTH=1: 0 - 1 = 1 with borrow and signed overflow, one SHIFT cycle
    @(negedge clk);
    chk("w1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid1) break;
    end
    chk("w1_latency", n, 1);
    @(negedge clk);
    chk("w1_result", result1, 1);
    chk("w1_borrow", borrow1, 1);
    chk("w1_zero", zero1, 0);
    chk("w1_overflow", overflow1, 1);
    @(posedge clk);
    #1;
    chk("w1_in_ready_post", in_ready1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor for the mini-cpu datapath. It computes a - b LSB-first, one bit per clock, through a single full_adder cell: b is inverted and the initial carry is 1. Operands enter and results leave over valid/ready handshakes. It also reports borrow, zero and signed-overflow flags, for use by the compare and branch logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair a, b presented.
in_ready  output  1  block can accept an operand pair.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  (a - b) mod 2^WIDTH.
borrow  output  1  1 when unsigned a < b.
zero  output  1  1 when result == 0.
overflow  output  1  signed overflow of a - b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, borrow=0, zero=0, overflow=0, internal shift registers, carry and counter all 0.
- Reset mid-operation: the operation is aborted immediately. No output handshake occurs and the block returns to IDLE.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid && in_ready: latch a_sh=a, b_sh=b, a_msb=a[WIDTH-1], b_msb=b[WIDTH-1]; set carry=1 and count=0; go to SHIFT.
- SHIFT:
  - in_ready=0 and out_valid=0.
  - Each cycle: full_adder(a=a_sh[0], b=~b_sh[0], carry_in=carry) gives sum and carry_out.
  - Register updates: result shift register <= {sum, res[WIDTH-1:1]}; a_sh, b_sh logically shifted right by 1; carry <= carry_out; count++.
  - When count==WIDTH-1 (this cycle processes the MSB), go to DONE.
- Latency: exactly WIDTH cycles in SHIFT. out_valid rises WIDTH clock edges after the accept edge.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs are held stable until out_ready is sampled high; on that edge, go to IDLE.
- Flags, registered on entry to DONE:
  - borrow = ~final carry.
  - zero = (final result == 0).
  - overflow = (a_msb != b_msb) && (result[WIDTH-1] != a_msb).
- Throughput: no overlap. A new operand cannot be accepted in the same cycle as the output handshake, so the minimum period is WIDTH+2 cycles per operation.
- Ignored inputs:
  - in_valid is ignored outside IDLE; a, b need not be held after acceptance.
  - out_ready is ignored outside DONE.
- WIDTH=1: SHIFT lasts one cycle; count width is max(1, $clog2(WIDTH)).
- result, borrow, zero and overflow keep their last values in IDLE. Consumers must qualify them with out_valid.

Decomposition:
- Shared package (mini_cpu_pkg): state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- One sub-module: the existing full_adder instantiated once, with ports sum, carry_out, a, b, carry_in. No other arithmetic operators are used on the operand path.
- The shift/count/FSM logic stays in serial_subtractor.

Test Plan:
WIDTH=8, out_ready=1:
- a=5, b=3 -> result=0x02, borrow=0, zero=0, overflow=0; out_valid exactly 8 edges after accept.
- a=3, b=5 -> result=0xFE, borrow=1, zero=0, overflow=0.
- a=0x80, b=0x01 -> result=0x7F, borrow=0, overflow=1.
- a=0x7F, b=0xFF -> result=0x80, borrow=1, overflow=1.
- a=0x07, b=0x07 -> result=0x00, zero=1, borrow=0.

Handshake and reset:
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and new in_valid ignored. Then out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-operation: drop rst_n after 3 SHIFT cycles -> out_valid=0, in_ready=1 and result=0 immediately (asynchronous). The next operation a=9, b=4 yields result=0x05.
- WIDTH=1 build: a=0, b=1 -> result=1, borrow=1, overflow=1 (0 - (-1) = +1 is unrepresentable), latency 1 cycle.
